// File: rtl/vend_pkg.sv
// Shared types for the vend dispenser: FSM state encoding, request record, change limits.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
package vend_pkg;

    localparam int CHG_W = 3;
    localparam logic [CHG_W-1:0] MAX_CHANGE = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SODA  = 3'd1,
        ST_EJECT = 3'd2,
        ST_WAITC = 3'd3,
        ST_FAULT = 3'd4
    } disp_state_e;

    typedef struct packed {
        logic [CHG_W-1:0] chg;
    } req_t;

    // Clamp an out-of-range change code to the largest legal nickel count.
    function automatic logic [CHG_W-1:0] sat_change(input logic [CHG_W-1:0] c);
        return (c > MAX_CHANGE) ? MAX_CHANGE : c;
    endfunction

endpackage

// File: rtl/vend_req_fifo.sv
// Generic synchronous FIFO, DEPTH entries of W bits, registered occupancy.
// Latency: a push is visible on pop_dat / !empty the cycle after it is written.
// Backpressure: push ignored when full unless a pop happens the same cycle; pop ignored when empty.
module vend_req_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 3
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign pop_dat = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally as DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/vend_dispenser.sv
// Dispenses a queued vend: runs the soda chute motor, then ejects owed nickels with sensor handshakes.
// Latency: soda_i to soda_motor_o is 2 cycles minimum (every request passes through the queue).
// Backpressure: none upstream; a request arriving with the queue full and no pop is dropped (overflow_o).
module vend_dispenser
    import vend_pkg::*;
#(
    parameter int QDEPTH      = 2,
    parameter int EJECT_CYC   = 4,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             soda_i,
    input  logic [CHG_W-1:0] change_i,
    input  logic             soda_done_i,
    input  logic             coin_done_i,
    output logic             soda_motor_o,
    output logic             nickel_eject_o,
    output logic             busy_o,
    output logic             overflow_o,
    output logic             bad_code_o,
    output logic             fault_o
);

    localparam int PW = $clog2(EJECT_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    disp_state_e      state;
    logic [PW-1:0]    pulse_cnt;
    logic [TW-1:0]    tmo_cnt;
    logic [CHG_W-1:0] nickels;

    req_t push_req;
    req_t pop_req;
    logic q_push;
    logic q_pop;
    logic q_full;
    logic q_empty;

    assign push_req.chg = sat_change(change_i);
    assign q_pop        = (state == ST_IDLE) && !q_empty;
    assign q_push       = soda_i && (!q_full || q_pop);
    assign busy_o       = ((state != ST_IDLE) && (state != ST_FAULT)) || !q_empty;

    vend_req_fifo #(
        .DEPTH (QDEPTH),
        .W     (CHG_W)
    ) u_req_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .push     (q_push),
        .push_dat (push_req),
        .pop      (q_pop),
        .pop_dat  (pop_req),
        .full     (q_full),
        .empty    (q_empty)
    );

    // Sticky overflow on a dropped request, and a one-cycle flag for an out-of-range change code.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_o <= 1'b0;
            bad_code_o <= 1'b0;
        end else begin
            if (soda_i && q_full && !q_pop) overflow_o <= 1'b1;
            bad_code_o <= soda_i && (change_i > MAX_CHANGE);
        end
    end

    // Dispense FSM; actuator outputs are registered and change on the same edge as the state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= ST_IDLE;
            pulse_cnt      <= '0;
            tmo_cnt        <= '0;
            nickels        <= '0;
            soda_motor_o   <= 1'b0;
            nickel_eject_o <= 1'b0;
            fault_o        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (q_pop) begin
                        nickels      <= pop_req.chg;
                        tmo_cnt      <= '0;
                        soda_motor_o <= 1'b1;
                        state        <= ST_SODA;
                    end
                end
                ST_SODA: begin
                    if (soda_done_i) begin
                        soda_motor_o <= 1'b0;
                        tmo_cnt      <= '0;
                        if (nickels != '0) begin
                            pulse_cnt      <= '0;
                            nickel_eject_o <= 1'b1;
                            state          <= ST_EJECT;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
                        soda_motor_o <= 1'b0;
                        fault_o      <= 1'b1;
                        state        <= ST_FAULT;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                ST_EJECT: begin
                    // Confirmations arriving while the solenoid is still pulsing are not counted.
                    if (pulse_cnt == PW'(EJECT_CYC - 1)) begin
                        nickel_eject_o <= 1'b0;
                        tmo_cnt        <= '0;
                        state          <= ST_WAITC;
                    end else begin
                        pulse_cnt <= pulse_cnt + PW'(1);
                    end
                end
                ST_WAITC: begin
                    if (coin_done_i) begin
                        nickels <= nickels - CHG_W'(1);
                        tmo_cnt <= '0;
                        if (nickels == CHG_W'(1)) begin
                            state <= ST_IDLE;
                        end else begin
                            pulse_cnt      <= '0;
                            nickel_eject_o <= 1'b1;
                            state          <= ST_EJECT;
                        end
                    end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
                        fault_o <= 1'b1;
                        state   <= ST_FAULT;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                ST_FAULT: begin
                    soda_motor_o   <= 1'b0;
                    nickel_eject_o <= 1'b0;
                    fault_o        <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_dispenser.sv
module tb_vend_dispenser;

    localparam int TMO = 1000;
    localparam int EJ  = 4;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b1;
    logic       soda_i = 1'b0;
    logic [2:0] change_i = 3'd0;
    logic       soda_done_i = 1'b0;
    logic       coin_done_i = 1'b0;
    logic       soda_motor_o;
    logic       nickel_eject_o;
    logic       busy_o;
    logic       overflow_o;
    logic       bad_code_o;
    logic       fault_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    vend_dispenser #(
        .QDEPTH      (2),
        .EJECT_CYC   (EJ),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .soda_i         (soda_i),
        .change_i       (change_i),
        .soda_done_i    (soda_done_i),
        .coin_done_i    (coin_done_i),
        .soda_motor_o   (soda_motor_o),
        .nickel_eject_o (nickel_eject_o),
        .busy_o         (busy_o),
        .overflow_o     (overflow_o),
        .bad_code_o     (bad_code_o),
        .fault_o        (fault_o)
    );

    typedef struct {
        logic       soda;
        logic [2:0] chg;
        logic       sdone;
        logic       cdone;
        logic       motor;
        logic       eject;
        logic       busy;
        logic       ovf;
        logic       bad;
        logic       fault;
    } vec_t;

    vec_t vecs [9];

    task automatic chkb(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Asserts reset mid-cycle, checks outputs drop at once, releases after two edges.
    task automatic do_reset(input string nm);
        #2 rst_ni = 1'b0;
        #1;
        chkb({nm, "_motor"}, soda_motor_o, 1'b0);
        chkb({nm, "_eject"}, nickel_eject_o, 1'b0);
        chkb({nm, "_busy"}, busy_o, 1'b0);
        chkb({nm, "_ovf"}, overflow_o, 1'b0);
        chkb({nm, "_bad"}, bad_code_o, 1'b0);
        chkb({nm, "_fault"}, fault_o, 1'b0);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
    endtask

    task automatic wait_motor(input string nm);
        int g = 0;
        while (!soda_motor_o && g < 10) begin
            step();
            g++;
        end
        chkb({nm, "_motor_on"}, soda_motor_o, 1'b1);
    endtask

    // Serves one vend already heading for the chute: drops the soda, then
    // answers each nickel pulse with a confirmation, checking pulse widths.
    // early_coin also raises coin_done_i during the first cycle of each pulse.
    task automatic run_vend(input int exp_n, input string nm, input logic early_coin);
        int n = 0;
        int w = 0;
        int guard = 0;
        wait_motor(nm);
        repeat (2) step();
        soda_done_i = 1'b1;
        step();
        soda_done_i = 1'b0;
        chkb({nm, "_motor_off"}, soda_motor_o, 1'b0);
        while (n < exp_n && guard < 200) begin
            if (nickel_eject_o) begin
                w++;
                coin_done_i = early_coin && (w == 1);
                step();
                coin_done_i = 1'b0;
            end else if (w > 0) begin
                chki({nm, "_pulse_width"}, w, EJ);
                n++;
                w = 0;
                coin_done_i = 1'b1;
                step();
                coin_done_i = 1'b0;
            end else begin
                step();
            end
            guard++;
        end
        chki({nm, "_nickels"}, n, exp_n);
    endtask

    // No further eject pulse may appear and the dispenser must go idle.
    task automatic expect_quiet(input string nm);
        logic seen = 1'b0;
        repeat (8) begin
            step();
            if (nickel_eject_o || soda_motor_o) seen = 1'b1;
        end
        chkb({nm, "_no_extra_actuation"}, seen, 1'b0);
        chkb({nm, "_busy_idle"}, busy_o, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int g;

        //        soda chg  sdn cdn  motor ej busy ovf bad flt
        vecs[0] = '{1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        step();
        do_reset("rst_init");

        // Plain vend with no change, then a bad code whose vend is finished by hand below.
        for (int i = 0; i < 9; i++) begin
            soda_i      = vecs[i].soda;
            change_i    = vecs[i].chg;
            soda_done_i = vecs[i].sdone;
            coin_done_i = vecs[i].cdone;
            step();
            chkb($sformatf("vec%0d_motor", i), soda_motor_o, vecs[i].motor);
            chkb($sformatf("vec%0d_eject", i), nickel_eject_o, vecs[i].eject);
            chkb($sformatf("vec%0d_busy", i), busy_o, vecs[i].busy);
            chkb($sformatf("vec%0d_ovf", i), overflow_o, vecs[i].ovf);
            chkb($sformatf("vec%0d_bad", i), bad_code_o, vecs[i].bad);
            chkb($sformatf("vec%0d_fault", i), fault_o, vecs[i].fault);
        end
        soda_i = 1'b0;
        change_i = 3'd0;
        soda_done_i = 1'b0;

        // change code 6 saturates to exactly four nickels
        run_vend(4, "bad6", 1'b0);
        expect_quiet("bad6");

        // three nickels; a premature confirmation during each pulse must not count
        soda_i = 1'b1;
        change_i = 3'd3;
        step();
        soda_i = 1'b0;
        change_i = 3'd0;
        run_vend(3, "chg3", 1'b1);
        expect_quiet("chg3");

        // four back-to-back requests with sensors stalled: fourth is dropped
        soda_i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            change_i = 3'(k);
            step();
            if (k == 3) chkb("ovf_before_drop", overflow_o, 1'b0);
        end
        soda_i = 1'b0;
        change_i = 3'd0;
        chkb("ovf_after_drop", overflow_o, 1'b1);
        run_vend(1, "q1", 1'b0);
        run_vend(2, "q2", 1'b0);
        run_vend(3, "q3", 1'b0);
        expect_quiet("q_drain");
        chkb("ovf_sticky", overflow_o, 1'b1);

        // chute never confirms: fault after TIMEOUT_CYC cycles in SODA
        do_reset("rst_ovf");
        soda_i = 1'b1;
        step();
        soda_i = 1'b0;
        wait_motor("tmo");
        cyc = 0;
        while (!fault_o && cyc < TMO + 100) begin
            step();
            cyc++;
        end
        chki("tmo_cycles", cyc, TMO);
        chkb("tmo_motor_off", soda_motor_o, 1'b0);
        chkb("tmo_busy", busy_o, 1'b0);
        soda_done_i = 1'b1;
        coin_done_i = 1'b1;
        step();
        soda_done_i = 1'b0;
        coin_done_i = 1'b0;
        // queue keeps filling while faulted
        soda_i = 1'b1;
        change_i = 3'd1;
        repeat (3) step();
        soda_i = 1'b0;
        change_i = 3'd0;
        repeat (20) step();
        chkb("fault_sticky", fault_o, 1'b1);
        chkb("fault_motor", soda_motor_o, 1'b0);
        chkb("fault_eject", nickel_eject_o, 1'b0);
        chkb("fault_busy_queue", busy_o, 1'b1);
        chkb("fault_ovf", overflow_o, 1'b1);

        // reset in the middle of a nickel pulse, with overflow set and two queued
        do_reset("rst_fault");
        soda_i = 1'b1;
        change_i = 3'd2;
        repeat (4) step();
        soda_i = 1'b0;
        change_i = 3'd0;
        chkb("mid_ovf_set", overflow_o, 1'b1);
        wait_motor("mid");
        soda_done_i = 1'b1;
        step();
        soda_done_i = 1'b0;
        chkb("mid_eject_on", nickel_eject_o, 1'b1);
        step();
        do_reset("rst_mid_eject");
        g = 0;
        repeat (5) begin
            step();
            if (soda_motor_o || busy_o) g++;
        end
        chki("post_reset_queue_empty", g, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vend_dispenser.md
Name: vend_dispenser

Overview:
Downstream of the coin-counting vending FSM. Consumes its one-cycle soda/change result and physically dispenses: drives the soda chute motor, then ejects the owed nickels one at a time with sensor confirmation. A small request queue absorbs back-to-back vends. A timeout watchdog raises a sticky fault on jammed hardware.

Parameters:
QDEPTH, 2, request queue entries (power of two, >=2)
EJECT_CYC, 4, cycles nickel_eject_o is held high per nickel
TIMEOUT_CYC, 1000, max cycles to wait for any sensor confirmation before fault

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_ni  input  1  asynchronous active-low reset
soda_i  input  1  vend request; each cycle high is one independent vend
change_i  input  3  nickels owed with that vend, sampled when soda_i=1; legal 0..4
soda_done_i  input  1  chute sensor, soda has dropped
coin_done_i  input  1  hopper sensor, one nickel has left
soda_motor_o  output  1  chute motor enable
nickel_eject_o  output  1  hopper solenoid pulse
busy_o  output  1  request in service or queue non-empty
overflow_o  output  1  sticky: request dropped because queue full
bad_code_o  output  1  one-cycle: change_i>4 seen with soda_i (value saturated to 4)
fault_o  output  1  sticky: sensor timeout

Behaviour:
- Reset (async assert, sync deassert handled by the reset source): all outputs 0, queue empty, FSM IDLE, counters 0. Reset mid-dispense abandons the request; motor/solenoid drop immediately.
- Enqueue: every cycle soda_i=1 pushes {change} (saturated to 4; bad_code_o=1 the following cycle). Queue full and no pop that cycle -> drop, set overflow_o. Full with simultaneous pop -> push accepted.
- Empty queue bypass not allowed: request always passes through the queue; IDLE pops when non-empty, min latency soda_i -> soda_motor_o = 2 cycles.
- FSM states: IDLE, SODA, EJECT, WAITC, FAULT.
- IDLE: queue non-empty -> pop, load nickel count, go SODA.
- SODA: soda_motor_o=1. soda_done_i=1 -> motor off same edge; count>0 -> EJECT else IDLE. Timer reaches TIMEOUT_CYC -> FAULT.
- EJECT: nickel_eject_o=1 for exactly EJECT_CYC cycles, then WAITC.
- WAITC: coin_done_i=1 -> count-1; count becomes 0 -> IDLE else EJECT. coin_done_i during EJECT is counted as the confirmation only if it arrives in WAITC; earlier pulses are ignored. Timeout -> FAULT.
- Timeout counter clears on every state entry; counts only in SODA and WAITC.
- FAULT: all actuators 0, fault_o=1, queue keeps accepting until full (overflow rules apply); exit only by reset.
- busy_o = (state!=IDLE && state!=FAULT) || queue non-empty.
- Sensor inputs outside their waiting states are ignored.

Decomposition:
- vend_pkg: state enum disp_state_e, CHG_W=3, MAX_CHANGE=4, request struct {chg}.
- Sub-module vend_req_fifo: synchronous FIFO, QDEPTH x CHG_W, push/pop/full/empty, async active-low reset, same-cycle push+pop when full allowed.
- Top holds FSM, eject pulse counter ($clog2(EJECT_CYC+1) bits), timeout counter ($clog2(TIMEOUT_CYC+1) bits), sticky flags.

Test Plan:
- soda_i=1, change_i=0 for 1 cycle; soda_done_i after 5 cycles -> soda_motor_o high 2 cycles after request, low after sensor, no nickel_eject_o, busy_o back to 0.
- change_i=3 -> after soda_done_i, three nickel_eject_o pulses each 4 cycles wide, each followed by coin_done_i -> returns to IDLE after third confirmation.
- soda_i high 4 consecutive cycles (change 1,2,3,4) with sensors stalled -> first popped, two queued, fourth dropped, overflow_o=1; remaining vends complete in order when sensors respond.
- change_i=6 with soda_i -> bad_code_o one cycle, exactly 4 nickels ejected.
- soda_done_i never asserted -> fault_o=1 at TIMEOUT_CYC cycles into SODA, soda_motor_o=0, stays until rst_ni low.
- rst_ni low mid EJECT pulse -> nickel_eject_o, busy_o, fault_o, overflow_o 0 immediately, queue empty after release.
